// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if - bundles every handshake and bus signal of the memory arbiter.
//
// Signal groups (names keep the arbiter-side direction suffix):
//   fetch requester : if_req_i, if_addr_i -> if_gnt_o, if_done_o, if_rdata_o
//   data requester  : d_req_i, d_we_i, d_addr_i, d_wdata_i -> d_gnt_o, d_done_o, d_rdata_o
//   status          : err_o (timeout flag, pulses with the done pulse)
//   memory port     : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i, mem_ack_i
//
// Modports:
//   slave  - the arbiter's view (it serves the two requesters)
//   master - the surrounding core + memory that drive the arbiter
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_done_o;
  logic [XLEN-1:0] if_rdata_o;

  logic            d_req_i;
  logic            d_we_i;
  logic [XLEN-1:0] d_addr_i;
  logic [XLEN-1:0] d_wdata_i;
  logic            d_gnt_o;
  logic            d_done_o;
  logic [XLEN-1:0] d_rdata_o;

  logic            err_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_ack_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_gnt_o, if_done_o, if_rdata_o,
    output d_gnt_o, d_done_o, d_rdata_o,
    output err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_gnt_o, if_done_o, if_rdata_o,
    input  d_gnt_o, d_done_o, d_rdata_o,
    input  err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter - shares one single-port memory between the instruction-fetch
// requester and the load/store requester of a single-cycle RV32 core.
//
// One transaction is in flight at a time. A request seen in IDLE is latched
// onto the memory port, the winner gets a one-cycle grant pulse, and the FSM
// waits in BUSY for mem_ack_i. If no ack arrives within TIMEOUT_CYCLES busy
// cycles the transaction is aborted: the owner gets done + err and its read
// data register is cleared. All outputs are registered.
//
// Ports:
//   clk_i  - clock, all state on the rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - mem_arbiter_if.slave (requester handshakes + memory port)
//
// Parameters:
//   XLEN           - address/data width (must match the interface)
//   TIMEOUT_CYCLES - busy cycles without ack before abort, 1..65535
//   CNT_W          - wait counter width, derived
//
// Optional feature (macro MEM_ARB_ROUND_ROBIN_EN):
//   defined   - a 1-bit round-robin pointer (reset to fetch) toggles after
//               every grant and picks the winner on simultaneous requests
//   undefined - data always beats fetch on simultaneous requests
module mem_arbiter #(
  parameter  int XLEN           = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            owner_data_q, owner_data_d;
  logic            grant_data;

  logic            mem_req_d, mem_we_d;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d;
  logic [XLEN-1:0] if_rdata_d, d_rdata_d;
  logic            if_gnt_d, d_gnt_d, if_done_d, d_done_d, err_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q = 1 means the data requester wins the next tie
  logic rr_q, rr_d;
  assign grant_data = bus.d_req_i && (!bus.if_req_i || rr_q);
`else
  assign grant_data = bus.d_req_i;
`endif

  // Next-state and next-output logic. Every registered output has a next
  // value here; pulses default to 0 and held values default to themselves.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_data_d = owner_data_q;
    mem_req_d    = bus.mem_req_o;
    mem_we_d     = bus.mem_we_o;
    mem_addr_d   = bus.mem_addr_o;
    mem_wdata_d  = bus.mem_wdata_o;
    if_rdata_d   = bus.if_rdata_o;
    d_rdata_d    = bus.d_rdata_o;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d         = rr_q;
`endif

    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (bus.if_req_i || bus.d_req_i) begin
          state_d      = BUSY;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          owner_data_d = grant_data;
          if (grant_data) begin
            mem_we_d    = bus.d_we_i;
            mem_addr_d  = bus.d_addr_i;
            mem_wdata_d = bus.d_wdata_i;
            d_gnt_d     = 1'b1;
          end else begin
            // fetches never write; drive zero data so the port is quiet
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr_i;
            mem_wdata_d = '0;
            if_gnt_d    = 1'b1;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d = ~rr_q;
`endif
        end
      end

      BUSY: begin
        // an ack in the timeout cycle wins, so it is tested first
        if (bus.mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (owner_data_q) begin
            d_done_d = 1'b1;
            if (!bus.mem_we_o) begin
              d_rdata_d = bus.mem_rdata_i;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (owner_data_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      owner_data_q    <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.if_rdata_o  <= '0;
      bus.d_rdata_o   <= '0;
      bus.if_gnt_o    <= 1'b0;
      bus.d_gnt_o     <= 1'b0;
      bus.if_done_o   <= 1'b0;
      bus.d_done_o    <= 1'b0;
      bus.err_o       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q            <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_data_q    <= owner_data_d;
      bus.mem_req_o   <= mem_req_d;
      bus.mem_we_o    <= mem_we_d;
      bus.mem_addr_o  <= mem_addr_d;
      bus.mem_wdata_o <= mem_wdata_d;
      bus.if_rdata_o  <= if_rdata_d;
      bus.d_rdata_o   <= d_rdata_d;
      bus.if_gnt_o    <= if_gnt_d;
      bus.d_gnt_o     <= d_gnt_d;
      bus.if_done_o   <= if_done_d;
      bus.d_done_o    <= d_done_d;
      bus.err_o       <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q            <= rr_d;
`endif
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester and its load/store requester.
- Lets the single-cycle RV32 core run from a single-port RAM. The core stalls on outstanding grants/completions.
- One transaction in flight at a time; registered request path; wait-state support via mem_ack_i; bus-timeout watchdog.

Parameters:
- XLEN, 32, address and data width.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ack_i before the transaction is aborted. Legal range 1..65535.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived, do not override).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  XLEN  fetch address
- if_gnt_o  out  1  one-cycle pulse, fetch accepted and address latched
- if_done_o  out  1  one-cycle pulse, fetch complete
- if_rdata_o  out  XLEN  fetch data, valid with if_done_o, held until next done
- d_req_i  in  1  data request, held until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  XLEN  data address
- d_wdata_i  in  XLEN  store data
- d_gnt_o  out  1  one-cycle pulse, data request accepted
- d_done_o  out  1  one-cycle pulse, data access complete
- d_rdata_o  out  XLEN  load data, valid with d_done_o, held until next done
- err_o  out  1  one-cycle pulse with the done pulse of a timed-out transaction
- mem_req_o  out  1  memory request, held high until ack or timeout
- mem_we_o  out  1  memory write strobe, qualified by mem_req_o
- mem_addr_o  out  XLEN  memory address
- mem_wdata_o  out  XLEN  memory write data
- mem_rdata_i  in  XLEN  memory read data, sampled when mem_ack_i=1
- mem_ack_i  in  1  memory completion, sampled only while mem_req_o=1

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state=IDLE; in-flight transaction dropped, no done pulse.
  - All outputs 0, including rdata registers and mem_addr_o/mem_wdata_o.
  - Wait counter 0; owner=fetch; rr pointer=fetch.
- FSM states are IDLE and BUSY.
- IDLE:
  - If any req_i is high at an edge: select a winner per the priority rule.
  - Latch the winner's addr/we/wdata into mem_* (fetch forces we=0), set mem_req_o=1, pulse the winner's gnt_o, record owner, clear counter, go to BUSY.
  - If no req: stay in IDLE, mem_req_o=0.
- Priority (macro absent): data beats fetch when both request in the same cycle.
- BUSY, mem_ack_i=1:
  - mem_req_o<=0.
  - If the owner is a read (fetch, or load), its rdata register <= mem_rdata_i. Stores leave d_rdata_o unchanged.
  - Owner's done_o pulses; go to IDLE.
- BUSY, no ack: counter increments.
  - When counter reaches TIMEOUT_CYCLES-1 with no ack: mem_req_o<=0, owner's done_o and err_o pulse, owner's rdata register <= 0, go to IDLE.
  - Ack arriving in the same cycle as the timeout condition takes precedence: normal completion, err_o=0.
- Requests arriving while BUSY wait; the requester must hold req and payload stable until its gnt.
- Latency:
  - Request at edge N (IDLE) gives gnt and mem_req_o high after edge N.
  - Ack at edge N+k (k≥1) gives done after edge N+k.
  - The next grant can be issued at edge N+k+1 (one IDLE cycle between transactions).
- gnt_o and done_o are never high for both requesters in the same cycle; each is exactly one cycle wide.
- mem_addr_o, mem_we_o and mem_wdata_o are stable for the whole time mem_req_o is high.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit rr pointer, initially fetch, toggles to the other requester after each grant.
  - On simultaneous requests the requester the pointer selects wins.
  - A lone request is always granted.
- Undefined: fixed data-over-fetch priority; no rr pointer.

Test Plan:
- Reset then lone fetch, if_addr_i=0x00000010, ack 1 cycle later with rdata 0x00500093:
  - if_gnt_o pulse, mem_addr_o=0x10, mem_we_o=0.
  - if_done_o pulse with if_rdata_o=0x00500093; err_o=0.
- Store d_addr_i=0x100, d_wdata_i=0xDEADBEEF, ack after 3 wait cycles:
  - mem_we_o=1 and mem_wdata_o=0xDEADBEEF held 4 cycles.
  - d_done_o pulse; d_rdata_o unchanged.
- Simultaneous if_req_i and d_req_i (load 0x200), macro undefined: d_gnt_o first; if_gnt_o one cycle after d_done_o.
  - With MEM_ARB_ROUND_ROBIN_EN, two consecutive simultaneous rounds: fetch is granted first, then data.
- Timeout, TIMEOUT_CYCLES=4, no ack:
  - mem_req_o high exactly 4 cycles.
  - Owner's done_o and err_o pulse together; rdata=0; FSM back in IDLE.
  - Repeat with ack in the 4th cycle: normal done, err_o=0.
- Assert rst_i mid-BUSY, then release: no done pulse, all outputs 0 immediately; a new fetch afterwards completes normally.
